fft_frame_ctrl: RTL and testbench



---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_frame_buf.sv | 30 +++
 rtl/fft_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT frame sequencer: state enum, complex sample, 8-lane frame.
// A frame is a packed array of cplx_t with lane k at index k, matching the core's bus packing.
package fft_pkg;
    localparam int N_PTS  = 8;
    localparam int IDX_W  = 3;
    localparam int CPLX_W = 32;

    typedef enum logic [1:0] {LOAD, WAIT, DRAIN} fft_state_e;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef cplx_t [N_PTS-1:0] frame_t;

    function automatic logic [N_PTS*CPLX_W-1:0] pack_lanes(input frame_t f, input logic sel_im);
        logic [N_PTS*CPLX_W-1:0] v;
        for (int k = 0; k < N_PTS; k++)
            v[k*CPLX_W +: CPLX_W] = sel_im ? f[k].im : f[k].re;
        return v;
    endfunction

    function automatic frame_t unpack_lanes(input logic [N_PTS*CPLX_W-1:0] re_v,
                                            input logic [N_PTS*CPLX_W-1:0] im_v);
        frame_t f;
        for (int k = 0; k < N_PTS; k++) begin
            f[k].re = re_v[k*CPLX_W +: CPLX_W];
            f[k].im = im_v[k*CPLX_W +: CPLX_W];
        end
        return f;
    endfunction
endpackage

// File: rtl/fft_frame_buf.sv
// 8-entry complex register file: indexed write, whole-frame load (load wins), indexed read.
// Written the cycle after wr_en/ld_en; no flow control of its own.
module fft_frame_buf
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  cplx_t            wr_dat,
    input  logic             ld_en,
    input  frame_t           ld_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output cplx_t            rd_dat,
    output frame_t           frame
);
    frame_t mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (ld_en)
            mem <= ld_dat;
        else if (wr_en)
            mem[wr_idx] <= wr_dat;
    end

    assign rd_dat = mem[rd_idx];
    assign frame  = mem;
endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an 8-point FFT core: collect 8 samples, run core with watchdog, replay 8 bins.
// Last beat at t -> fft_en at t+1; capture at c -> bin 0 at c+1; out_ready low freezes the bin stream.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_W  = CPLX_W,
    parameter int MIN_LAT = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_real,
    input  logic [DATA_W-1:0]     in_imag,
    input  logic                  in_last,
    output logic                  fft_en,
    output logic [8*DATA_W-1:0]   fft_x_real,
    output logic [8*DATA_W-1:0]   fft_x_imag,
    input  logic                  fft_valid,
    input  logic [8*DATA_W-1:0]   fft_y_real,
    input  logic [8*DATA_W-1:0]   fft_y_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_imag,
    output logic [2:0]            out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_len,
    output logic                  err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

    fft_state_e       state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] wait_cnt;

    cplx_t            in_smp;
    frame_t           in_frame;
    frame_t           y_frame;
    cplx_t            res_nxt;
    cplx_t            in_rd_unused;
    frame_t           res_frame_unused;
    logic [IDX_W-1:0] rd_nxt;
    logic             in_fire;
    logic             cap;

    assign in_smp  = '{re: in_real, im: in_imag};
    assign y_frame = unpack_lanes(fft_y_real, fft_y_imag);
    assign rd_nxt  = rd_idx + IDX_W'(1);
    assign in_fire = in_valid && in_ready;
    assign cap     = (state == WAIT) && fft_valid && (wait_cnt >= CNT_W'(MIN_LAT));

    fft_frame_buf u_in_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_fire),
        .wr_idx (wr_idx),
        .wr_dat (in_smp),
        .ld_en  (1'b0),
        .ld_dat ('0),
        .rd_idx ('0),
        .rd_dat (in_rd_unused),
        .frame  (in_frame)
    );

    // Result buffer is read one bin ahead so the registered output can advance on each accept.
    fft_frame_buf u_res_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (1'b0),
        .wr_idx ('0),
        .wr_dat ('0),
        .ld_en  (cap),
        .ld_dat (y_frame),
        .rd_idx (rd_nxt),
        .rd_dat (res_nxt),
        .frame  (res_frame_unused)
    );

    assign fft_x_real = pack_lanes(in_frame, 1'b0);
    assign fft_x_imag = pack_lanes(in_frame, 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            wr_idx      <= '0;
            rd_idx      <= '0;
            wait_cnt    <= '0;
            in_ready    <= 1'b1;
            fft_en      <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_index   <= '0;
            out_real    <= '0;
            out_imag    <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (wr_idx == LAST_IDX) begin
                            err_len  <= !in_last;
                            wr_idx   <= '0;
                            wait_cnt <= '0;
                            in_ready <= 1'b0;
                            fft_en   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= WAIT;
                        end else if (in_last) begin
                            // Short frame: drop it but leave the stale samples in the buffer.
                            err_len <= 1'b1;
                            wr_idx  <= '0;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cap) begin
                        fft_en    <= 1'b0;
                        out_valid <= 1'b1;
                        out_index <= '0;
                        out_last  <= 1'b0;
                        out_real  <= y_frame[0].re;
                        out_imag  <= y_frame[0].im;
                        rd_idx    <= '0;
                        state     <= DRAIN;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        fft_en      <= 1'b0;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        wr_idx      <= '0;
                        state       <= LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            rd_idx    <= '0;
                            wr_idx    <= '0;
                            state     <= LOAD;
                        end else begin
                            rd_idx    <= rd_nxt;
                            out_index <= rd_nxt;
                            out_last  <= (rd_nxt == LAST_IDX);
                            out_real  <= res_nxt.re;
                            out_imag  <= res_nxt.im;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: core stub, random stimulus, and a timeline/scoreboard model checked every cycle.
module tb_fft_frame_ctrl;
    localparam int DW      = 32;
    localparam int MIN_LAT = 3;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [DW-1:0]   in_real = '0, in_imag = '0;
    logic            fft_en, fft_valid = 1'b0;
    logic [8*DW-1:0] fft_x_real, fft_x_imag;
    logic [8*DW-1:0] fft_y_real = '0, fft_y_imag = '0;
    logic            out_valid, out_ready = 1'b1;
    logic [DW-1:0]   out_real, out_imag;
    logic [2:0]      out_index;
    logic            out_last, busy, err_len, err_timeout;

    fft_frame_ctrl #(.DATA_W(DW), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .fft_en(fft_en), .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
        .fft_valid(fft_valid), .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .busy(busy),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    bit rst_q = 1'b0;

    always @(posedge clk) begin
        cyc++;
        rst_q = rst;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s cycle %0d: wait bound expired, got no event, want event", name, cyc);
    endtask

    // Core stub: result = input with real part +1, valid from WAIT index stub_lat onwards.
    int stub_lat = 3;
    bit stub_always = 1'b0;
    int widx = 0;
    always @(posedge clk) begin
        #1;
        if (fft_en) begin
            fft_valid = (widx >= stub_lat);
            widx++;
            for (int k = 0; k < 8; k++) begin
                fft_y_real[k*DW +: DW] = fft_x_real[k*DW +: DW] + 32'd1;
                fft_y_imag[k*DW +: DW] = fft_x_imag[k*DW +: DW];
            end
        end else begin
            widx = 0;
            fft_valid = stub_always;
            for (int k = 0; k < 8; k++) begin
                fft_y_real[k*DW +: DW] = $urandom();
                fft_y_imag[k*DW +: DW] = $urandom();
            end
        end
    end

    int rdy_mode = 0, rdy_ph = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
                rdy_ph++;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Model: sample buffer, expected bin queue, and the cycle windows of WAIT / DRAIN / error pulses.
    logic [31:0] m_re [8];
    logic [31:0] m_im [8];
    logic [31:0] q_re [$];
    logic [31:0] q_im [$];
    int m_cnt, m_cap, en_from, en_to, drain_from, len_err_at, to_at;
    bit checking = 1'b0, after_rst = 1'b0;
    bit e_en, e_ov, e_ir;
    logic [255:0] x_re, x_im;

    always @(negedge clk) begin
        if (rst_q) begin
            for (int k = 0; k < 8; k++) begin m_re[k] = '0; m_im[k] = '0; end
            q_re.delete(); q_im.delete();
            m_cnt = 0; en_from = -10; en_to = -20; drain_from = 0; len_err_at = -1; to_at = -1;
            checking = 1'b1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
        end
        if (checking) begin
            e_en = (cyc >= en_from) && (cyc <= en_to);
            e_ov = (q_re.size() != 0) && (cyc >= drain_from);
            e_ir = !e_en && !e_ov;
            chk("in_ready", in_ready, e_ir);
            chk("fft_en", fft_en, e_en);
            chk("out_valid", out_valid, e_ov);
            chk("busy", busy, !e_ir);
            chk("err_len", err_len, cyc == len_err_at);
            chk("err_timeout", err_timeout, cyc == to_at);
            for (int k = 0; k < 8; k++) begin
                x_re[k*32 +: 32] = m_re[k];
                x_im[k*32 +: 32] = m_im[k];
            end
            chk("fft_x_real", fft_x_real, x_re);
            chk("fft_x_imag", fft_x_imag, x_im);
            if (e_ov) begin
                chk("out_real", out_real, q_re[0]);
                chk("out_imag", out_imag, q_im[0]);
                chk("out_index", out_index, 8 - q_re.size());
                chk("out_last", out_last, q_re.size() == 1);
            end
            if (after_rst) begin
                chk("rst_out_real", out_real, 0);
                chk("rst_out_imag", out_imag, 0);
                chk("rst_out_index", out_index, 0);
                chk("rst_out_last", out_last, 0);
            end
            if (in_valid && e_ir) begin
                m_re[m_cnt] = in_real;
                m_im[m_cnt] = in_imag;
                m_cnt++;
                if (m_cnt == 8) begin
                    if (!in_last) len_err_at = cyc + 1;
                    m_cnt = 0;
                    m_cap = (stub_lat > MIN_LAT) ? stub_lat : MIN_LAT;
                    en_from = cyc + 1;
                    if (m_cap <= TIMEOUT - 1) begin
                        en_to = cyc + 1 + m_cap;
                        drain_from = cyc + 2 + m_cap;
                        for (int k = 0; k < 8; k++) begin
                            q_re.push_back(m_re[k] + 32'd1);
                            q_im.push_back(m_im[k]);
                        end
                    end else begin
                        en_to = cyc + TIMEOUT;
                        to_at = cyc + 1 + TIMEOUT;
                    end
                end else if (in_last) begin
                    len_err_at = cyc + 1;
                    m_cnt = 0;
                end
            end
            if (e_ov && out_ready) begin
                void'(q_re.pop_front());
                void'(q_im.pop_front());
            end
        end
    end

    int t_acc;

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_beat(input logic [31:0] re, input logic [31:0] im, input bit last);
        int n;
        in_valid = 1'b1; in_real = re; in_imag = im; in_last = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) bound_fail("send_beat");
        t_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        in_real = $urandom(); in_imag = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int len, input bit with_last, input bit gaps);
        for (int k = 0; k < len; k++) begin
            send_beat($urandom(), $urandom(), with_last && (k == len - 1));
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready && q_re.size() == 0 && cyc > en_to) && n < 300);
        if (n >= 300) bound_fail("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 60);
        if (!out_valid) bound_fail(name);
    endtask

    int t_last, n;
    logic [31:0] s0;

    initial begin
        #1000000;
        $display("FAIL global_watchdog: simulation time limit reached, got hang, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic frame: real = k*0x100, latency-3 stub.
        for (int k = 0; k < 8; k++) send_beat(32'(k * 256), 32'd0, k == 7);
        t_last = t_acc;
        @(negedge clk);
        chk("basic_en_rise", fft_en, 1);
        chk("basic_in_ready_drop", in_ready, 0);
        wait_out_valid("basic_out_valid");
        chk("basic_bin0_latency", cyc - t_last, 5);
        for (int k = 0; k < 8; k++) begin
            chk("basic_bin_real", out_real, 32'(k * 256 + 1));
            chk("basic_bin_index", out_index, k);
            chk("basic_bin_last", out_last, k == 7);
            @(negedge clk);
        end
        chk("basic_in_ready_back", in_ready, 1);
        @(posedge clk); #1;

        // Backpressure 1,0,0,1.
        rdy_mode = 1; rdy_ph = 0;
        send_frame(8, 1'b1, 1'b0);
        wait_idle();
        rdy_mode = 0;

        // Short frame then a good frame.
        send_frame(4, 1'b0, 1'b0);
        send_beat($urandom(), $urandom(), 1'b1);
        @(negedge clk);
        chk("short_err_len", err_len, 1);
        @(posedge clk); #1;
        s0 = $urandom();
        send_beat(s0, $urandom(), 1'b0);
        send_frame(7, 1'b1, 1'b0);
        wait_out_valid("short_next_out_valid");
        chk("short_next_bin0", out_real, s0 + 32'd1);
        wait_idle();

        // Timeout: stub never answers.
        stub_lat = 1000;
        send_frame(8, 1'b1, 1'b0);
        t_last = t_acc;
        n = 0;
        do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
        if (!err_timeout) bound_fail("timeout_pulse");
        else begin
            chk("timeout_at", cyc - t_last, 17);
            chk("timeout_en_drop", fft_en, 0);
            chk("timeout_in_ready", in_ready, 1);
        end
        wait_idle();

        // Stale valid in LOAD, early valid in WAIT.
        stub_lat = 0; stub_always = 1'b1;
        idle(5);
        send_frame(8, 1'b1, 1'b0);
        t_last = t_acc;
        wait_out_valid("early_out_valid");
        chk("early_capture_latency", cyc - t_last, 5);
        wait_idle();
        stub_lat = 3; stub_always = 1'b0;

        // Reset while bin 3 is on the output.
        send_frame(8, 1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_index == 3) && n < 60);
        if (n >= 60) bound_fail("rst_drain_bin3");
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_drain_out_valid", out_valid, 0);
        chk("rst_drain_in_ready", in_ready, 1);
        chk("rst_drain_out_real", out_real, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(1);
        send_frame(8, 1'b1, 1'b0);
        wait_idle();

        // Random traffic.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 9))
                0:       stub_lat = 1000;
                1, 2:    stub_lat = 0;
                default: stub_lat = $urandom_range(3, 16);
            endcase
            stub_always = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       send_frame($urandom_range(1, 7), 1'b1, 1'b1);
                1:       send_frame(8, 1'b0, 1'b1);
                default: send_frame(8, 1'b1, 1'b1);
            endcase
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
